// File: rtl/quadrature_encoder_gen.sv
// Quadrature encoder emulator: emits a commanded number of A/B edges at a
// programmable spacing, tracking position within one revolution and an index pulse.
module quadrature_encoder_gen #(
  parameter int COUNTS_PER_REV = 360,
  parameter int GAP_W          = 16,
  localparam int POS_W         = $clog2(COUNTS_PER_REV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  input  logic [15:0]      cmd_count,
  input  logic [GAP_W-1:0] edge_gap,
  output logic             cmd_ready,
  output logic             quadA_out,
  output logic             quadB_out,
  output logic             quadI_out,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position,
  output logic             dbg_state_o
);

  // Handshake: a command transfers on a rising clk edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready never depends on cmd_valid.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [GAP_W-1:0] MIN_GAP = GAP_W'(4);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(COUNTS_PER_REV - 1);

  logic [0:0]       state_q, state_d;
  logic             a_q, a_d, b_q, b_d, i_q, i_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [15:0]      remain_q, remain_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             done_q, done_d;

  logic [GAP_W-1:0] gap_eff;
  logic [POS_W-1:0] pos_step;
  logic             a_step, b_step;

  assign gap_eff = (edge_gap < MIN_GAP) ? MIN_GAP : edge_gap;

  // Gray-code advance: forward is 00->10->11->01, reverse walks it backwards.
  assign a_step = dir_q ? ~b_q : b_q;
  assign b_step = dir_q ? a_q : ~a_q;

  always_comb begin
    pos_step = pos_q;
    if (dir_q) begin
      pos_step = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
    end else begin
      pos_step = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
    end
  end

  assign cmd_ready = reset & enable & (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    i_d       = i_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    remain_d  = remain_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          dir_d = cmd_dir;
          gap_d = gap_eff;
          if (cmd_count == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d   = RUN;
            remain_d  = cmd_count;
            gap_cnt_d = gap_eff;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          // Abort wins over a coinciding edge so no edge follows the enable drop.
          state_d   = IDLE;
          done_d    = 1'b1;
          remain_d  = '0;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          a_d       = a_step;
          b_d       = b_step;
          pos_d     = pos_step;
          i_d       = (pos_step == '0);
          remain_d  = remain_q - 16'd1;
          gap_cnt_d = gap_q;
          if (remain_q == 16'd1) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            gap_cnt_d = '0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      i_q       <= 1'b0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      remain_q  <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      i_q       <= i_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      remain_q  <= remain_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

  assign quadA_out   = a_q;
  assign quadB_out   = b_q;
  assign quadI_out   = i_q;
  assign position    = pos_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule
